// File: rtl/timer_pkg.sv
// Shared types for the tick timer: FSM state and count-mode encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_FREE    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_t;

    function automatic mode_t to_mode(input logic oneshot_bit);
        return oneshot_bit ? MODE_ONESHOT : MODE_FREE;
    endfunction

endpackage

// File: rtl/adder_n.sv
// Parametrised N-bit ripple-carry adder.
module adder_n #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/tick_timer.sv
// Tick timer: counts 0..P in free-run (wrapping) or one-shot mode, with a
// registered terminal-count pulse. The FSM state is exported on state_o for debug.
module tick_timer
    import timer_pkg::*;
#(
    parameter int N               = 3,
    parameter bit ONESHOT_DEFAULT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic         oneshot,
    input  logic [N-1:0] period,
    output logic [N-1:0] tick,
    output logic         tc,
    output logic         busy,
    output logic         done,
    output state_t       state_o
);

    state_t       state_q, state_d;
    logic [N-1:0] tick_q, tick_d;
    logic [N-1:0] p_q, p_d;
    mode_t        mode_q, mode_d;
    logic         tc_q, tc_d;

    logic [N-1:0] tick_inc;
    logic         unused_cout;

    // The carry is never needed: tick only increments while below P_q.
    adder_n #(.W(N)) u_inc (
        .a    (tick_q),
        .b    ({N{1'b0}}),
        .cin  (1'b1),
        .s    (tick_inc),
        .cout (unused_cout)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        p_d     = p_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;

        // stop beats start, and both beat ena.
        if (stop) begin
            state_d = IDLE;
            tick_d  = '0;
        end else if (start) begin
            state_d = RUN;
            tick_d  = '0;
            p_d     = period;
            mode_d  = to_mode(oneshot);
        end else begin
            unique case (state_q)
                IDLE: tick_d = '0;
                RUN: begin
                    if (ena) begin
                        if (tick_q == p_q) begin
                            tc_d = 1'b1;
                            if (mode_q == MODE_ONESHOT) begin
                                state_d = DONE;
                            end else begin
                                tick_d = '0;
                                p_d    = period;
                            end
                        end else begin
                            tick_d = tick_inc;
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            p_q     <= '0;
            mode_q  <= to_mode(ONESHOT_DEFAULT);
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

    assign tick    = tick_q;
    assign tc      = tc_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign state_o = state_q;

endmodule
